serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial adder sequencer. It time-shares one data-flow full-adder cell across a WIDTH-bit add, one bit per clock.
- Accepts operands on a start strobe.
- Walks LSB to MSB through the cell, with a registered carry between bits.
- Presents the result with a one-cycle done pulse.
- Sits between probe/stimulus logic or a UART command decoder and the arithmetic cell, trading latency for a single adder instance.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only in IDLE
- a  input  WIDTH  operand A, sampled on accepted start
- b  input  WIDTH  operand B, sampled on accepted start
- cin  input  1  carry-in, sampled on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result, held until next completion
- cout  output  1  final carry, held with sum

Behaviour:
- Reset values (rst_n low at a clk edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, bit counter and carry reg cleared.
- Reset is synchronous only: no effect between edges.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE:
  - On start=1: latch a->opa, b->opb, cin->carry; cnt=0; go SHIFT.
  - Otherwise stay.
- SHIFT, each cycle:
  - Cell evaluates opa[0], opb[0], carry.
  - Cell sum bit shifts into MSB of the working result register; opa/opb shift right by one.
  - carry <= cell carry; cnt++.
  - When cnt==WIDTH-1, go DONE that edge.
- DONE:
  - sum <= working result; cout <= carry; done=1 for exactly this cycle.
  - Next state IDLE unconditionally.
- Latency: start sampled at edge 0 -> busy high cycles 1..WIDTH -> done high in cycle WIDTH+1, with sum/cout valid in that same cycle.
- Result is exact: {cout,sum} = a+b+cin, modulo 2^(WIDTH+1).
- Simultaneous/boundary conditions:
  - start while in SHIFT or DONE is ignored and not queued.
  - Input changes after acceptance have no effect.
  - sum/cout keep the previous result throughout SHIFT; they update only on entry to DONE.
  - Back-to-back ops: start asserted in the cycle after done is accepted, giving a minimum issue interval of WIDTH+2 cycles.
  - WIDTH=1: a single SHIFT cycle, then DONE.
  - Reset mid-SHIFT aborts the operation, no done pulse, and clears sum/cout to 0.
- Counter width: $clog2(WIDTH+1) bits; no wrap during valid operation.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - When sub=1: opb is latched as ~b and the initial carry as 1, so {cout,sum}=a-b. cin is ignored; cout=1 means no borrow.
  - When sub=0: behaviour is identical to the add path.
- Undefined: no sub port; add only; logic identical to the base description.

Decomposition:
- Package serial_adder_pkg:
  - state typedef (IDLE, SHIFT, DONE) and its encoding constants.
  - Helper function for counter width.
- Sub-module fa_cell: combinational 1-bit full adder ({co,s}=x+y+ci), instantiated once.
- All sequencing, shift registers and the FSM live in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'hA5, cin=0, start one cycle -> busy high 8 cycles, done pulse in cycle 9, sum=8'hFF, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start held high continuously, a=8'h03, b=8'h04 -> new op every 10 cycles. While busy, change a to 8'hF0 -> result still 8'h07. sum holds its old value until done.
- rst_n low at SHIFT cycle 4 of an op -> no done pulse; sum=0, cout=0, busy=0 next cycle. A fresh op afterwards completes correctly.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=8'h10, b=8'h01 -> sum=8'h0F, cout=1.
  - sub=1, a=8'h00, b=8'h01 -> sum=8'hFF, cout=0.
- WIDTH=1 build: a=1, b=1, cin=1 -> done in cycle 2, sum=1, cout=1. Also run a randomized loop of 200 ops on WIDTH=8 against the a+b+cin reference.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the bit-counter width helper.
package serial_adder_pkg;

    // Two-bit state encoding, kept as named constants so the enum and any
    // debug/probe logic agree on the values.
    localparam logic [1:0] ENC_IDLE  = 2'b00;
    localparam logic [1:0] ENC_SHIFT = 2'b01;
    localparam logic [1:0] ENC_DONE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        SHIFT = ENC_SHIFT,
        DONE  = ENC_DONE
    } state_t;

    // Counter must be able to represent 0..WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// fa_cell: purely combinational 1-bit full adder, {co,s} = x + y + ci.
// A single instance is time-shared by serial_adder_ctrl.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {1'b0, ci};

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder. Operands are captured on an
// accepted start, walked LSB to MSB through one fa_cell with a registered
// carry, and the result is presented with a one-cycle done pulse.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cell_s;
    logic             cell_co;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Operand B and initial carry as loaded on start; subtraction is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    fa_cell u_fa (
        .x  (opa[0]),
        .y  (opb[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // Working result after this cycle's bit enters at the MSB.
    always_comb begin
        // NOTE: assign a full default first so no path leaves work_next
        // unassigned (which would infer a latch).
        work_next            = work >> 1;
        work_next[WIDTH-1]   = cell_s;
    end

    // Sequencer FSM with registered busy/done/sum/cout.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; state registers use
        // non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            work  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b_load;
                        carry <= c_load;
                        work  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= cell_co;
                    work  <= work_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Last bit: result becomes visible together with done.
                        sum   <= work_next;
                        cout  <= cell_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1).
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
    logic       sub1;
`endif

    logic       s1_start;
    logic [0:0] s1_a;
    logic [0:0] s1_b;
    logic       s1_cin;
    logic       s1_busy;
    logic       s1_done;
    logic [0:0] s1_sum;
    logic       s1_cout;

    int errors = 0;
    int checks = 0;

    // Expected held result of the WIDTH=8 instance.
    logic [7:0] hold_s;
    logic       hold_c;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s1_start),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub1),
`endif
        .a     (s1_a),
        .b     (s1_b),
        .cin   (s1_cin),
        .busy  (s1_busy),
        .done  (s1_done),
        .sum   (s1_sum),
        .cout  (s1_cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
        end
        checks++;
        if ({s1_busy, s1_done, s1_cout, s1_sum} !== 4'd0) begin
            errors++;
            $display("FAIL reset1: busy=%b done=%b cout=%b sum=%b, want all 0", s1_busy, s1_done, s1_cout, s1_sum);
        end
        rst_n = 1'b1;
        hold_s = 8'h00;
        hold_c = 1'b0;
        tick();
    endtask

    // One full operation with cycle-exact timing checks; called in IDLE.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input logic [7:0] es, input logic ec, input string nm);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ta; b = ~tb_v; cin = ~tc;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if ({busy, done, cout, sum} !== {1'b1, 1'b0, hold_c, hold_s}) begin
                errors++;
                $display("FAIL %s shift c%0d: busy=%b done=%b cout=%b sum=%h, want 1 0 %b %h",
                         nm, i, busy, done, cout, sum, hold_c, hold_s);
            end
            tick();
        end
        checks++;
        if ({busy, done, cout, sum} !== {1'b0, 1'b1, ec, es}) begin
            errors++;
            $display("FAIL %s done: busy=%b done=%b cout=%b sum=%h, want 0 1 %b %h",
                     nm, busy, done, cout, sum, ec, es);
        end
        hold_s = es;
        hold_c = ec;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b, want 0 0", nm, busy, done);
        end
    endtask

    task automatic test_add();
        do_op(8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0, "add_5a_a5");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");
    endtask

    task automatic test_back_to_back();
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b busy c1: got %b want 1", busy);
        end
        tick();
        a = 8'hF0;
        for (int i = 2; i <= 8; i++) begin
            checks++;
            if ({busy, done, cout, sum} !== {1'b1, 1'b0, hold_c, hold_s}) begin
                errors++;
                $display("FAIL b2b shift c%0d: busy=%b done=%b cout=%b sum=%h, want 1 0 %b %h",
                         i, busy, done, cout, sum, hold_c, hold_s);
            end
            tick();
        end
        checks++;
        if ({done, cout, sum} !== {1'b1, 1'b0, 8'h07}) begin
            errors++;
            $display("FAIL b2b first done: done=%b cout=%b sum=%h, want 1 0 07", done, cout, sum);
        end
        hold_s = 8'h07;
        hold_c = 1'b0;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL b2b idle c10: busy=%b done=%b, want 0 0", busy, done);
        end
        tick();
        checks++;
        if ({busy, sum} !== {1'b1, 8'h07}) begin
            errors++;
            $display("FAIL b2b reissue c11: busy=%b sum=%h, want 1 07", busy, sum);
        end
        start = 1'b0;
        repeat (8) tick();
        checks++;
        if ({done, cout, sum} !== {1'b1, 1'b0, 8'hF4}) begin
            errors++;
            $display("FAIL b2b second done: done=%b cout=%b sum=%h, want 1 0 f4", done, cout, sum);
        end
        hold_s = 8'hF4;
        hold_c = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        logic saw_done;
        a = 8'h5A; b = 8'hA5; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            errors++;
            $display("FAIL midreset: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
        end
        hold_s = 8'h00;
        hold_c = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midreset_quiet: got activity after abort, want none");
        end
        do_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, "after_reset");
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        sub = 1'b1;
        do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, "sub_10_01");
        do_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, "sub_00_01");
        sub = 1'b0;
    endtask
`endif

    task automatic test_width1();
        logic [1:0] exp;
        for (int v = 0; v < 8; v++) begin
            s1_a = v[2:2]; s1_b = v[1:1]; s1_cin = v[0];
            exp = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
            s1_start = 1'b1;
            tick();
            s1_start = 1'b0;
            checks++;
            if ({s1_busy, s1_done} !== 2'b10) begin
                errors++;
                $display("FAIL w1 v%0d c1: busy=%b done=%b, want 1 0", v, s1_busy, s1_done);
            end
            tick();
            checks++;
            if ({s1_busy, s1_done, s1_cout, s1_sum} !== {2'b01, exp}) begin
                errors++;
                $display("FAIL w1 v%0d done: busy=%b done=%b cout=%b sum=%b, want 0 1 %b %b",
                         v, s1_busy, s1_done, s1_cout, s1_sum, exp[1], exp[0]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] r;
        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            r  = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            do_op(ra, rb, rc, r[7:0], r[8], "rand");
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0; sub1 = 1'b0;
`endif
        hold_s = 8'h00; hold_c = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_mid_reset();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_width1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
